// File: rtl/ex_wb_stage.sv
// Execute-to-writeback stage: 2-entry skid buffer holding ALU/shifter results, plus youngest-entry forwarding.
// Latency: one cycle from an accepted push to OutValid with that data; one result per cycle sustained.
// Backpressure: i_in_ready depends only on the registered entry count (and reset); optional flags via EX_WB_FLAGS_EN.
module ex_wb_stage #(
    parameter int WIDTH = 16,
    parameter int RD_W  = 3
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_flush,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    input  logic [WIDTH-1:0] i_in_result,
    input  logic [RD_W-1:0]  i_in_rd,
    input  logic             i_in_write_en,
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output logic [WIDTH-1:0] o_out_result,
    output logic [RD_W-1:0]  o_out_rd,
    output logic             o_out_write_en,
    output logic             o_out_zero,
    output logic             o_out_neg,
    output logic             o_fwd_valid,
    output logic [RD_W-1:0]  o_fwd_rd,
    output logic [WIDTH-1:0] o_fwd_result
);

    // Entry storage, indexed by the 1-bit head/tail pointers.
    logic [WIDTH-1:0] r_result [2];
    logic [RD_W-1:0]  r_rd     [2];
    logic             r_we     [2];
    logic             r_head;
    logic             r_tail;
    logic [1:0]       r_count;

    logic             w_push;
    logic             w_pop;
    logic             w_young;

    // Ready never looks at i_out_ready, so there is no combinational path from writeback back to execute.
    assign o_in_ready  = !i_rst && (r_count != 2'd2);
    assign o_out_valid = (r_count != 2'd0);
    assign w_push      = i_in_valid && o_in_ready;
    assign w_pop       = o_out_valid && i_out_ready;
    // Youngest entry sits one slot behind the tail (mod 2).
    assign w_young     = ~r_tail;

    assign o_out_result   = r_result[r_head];
    assign o_out_rd       = r_rd[r_head];
    assign o_out_write_en = r_we[r_head];

    assign o_fwd_valid  = o_out_valid && r_we[w_young];
    assign o_fwd_rd     = r_rd[w_young];
    assign o_fwd_result = r_result[w_young];

    // Pointer and occupancy update; reset beats flush, flush drops everything including this cycle's push.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_flush) begin
            r_head  <= 1'b0;
            r_tail  <= 1'b0;
            r_count <= 2'd0;
        end else begin
            if (w_push) r_tail <= ~r_tail;
            if (w_pop)  r_head <= ~r_head;
            if (w_push && !w_pop)      r_count <= r_count + 2'd1;
            else if (w_pop && !w_push) r_count <= r_count - 2'd1;
        end
    end

    // Payload write at the tail; storage is zeroed on reset so idle outputs read as 0.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < 2; i++) begin
                r_result[i] <= '0;
                r_rd[i]     <= '0;
                r_we[i]     <= 1'b0;
            end
        end else if (w_push && !i_flush) begin
            r_result[r_tail] <= i_in_result;
            r_rd[r_tail]     <= i_in_rd;
            r_we[r_tail]     <= i_in_write_en;
        end
    end

`ifdef EX_WB_FLAGS_EN
    logic r_zero [2];
    logic r_neg  [2];

    // Flags are computed once from the incoming result and travel with the entry.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < 2; i++) begin
                r_zero[i] <= 1'b0;
                r_neg[i]  <= 1'b0;
            end
        end else if (w_push && !i_flush) begin
            r_zero[r_tail] <= (i_in_result == '0);
            r_neg[r_tail]  <= i_in_result[WIDTH-1];
        end
    end

    assign o_out_zero = r_zero[r_head];
    assign o_out_neg  = r_neg[r_head];
`else
    assign o_out_zero = 1'b0;
    assign o_out_neg  = 1'b0;
`endif

endmodule

// File: tb/tb_ex_wb_stage.sv
module tb_ex_wb_stage;
    localparam int WIDTH = 16;
    localparam int RD_W  = 3;
`ifdef EX_WB_FLAGS_EN
    localparam bit FLAGS = 1'b1;
`else
    localparam bit FLAGS = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst, flush, in_valid, in_we, out_ready;
    logic [WIDTH-1:0] in_result;
    logic [RD_W-1:0]  in_rd;
    logic             in_ready, out_valid, out_we, out_zero, out_neg, fwd_valid;
    logic [WIDTH-1:0] out_result, fwd_result;
    logic [RD_W-1:0]  out_rd, fwd_rd;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    ex_wb_stage #(.WIDTH(WIDTH), .RD_W(RD_W)) dut (
        .i_clk(clk), .i_rst(rst), .i_flush(flush),
        .i_in_valid(in_valid), .o_in_ready(in_ready),
        .i_in_result(in_result), .i_in_rd(in_rd), .i_in_write_en(in_we),
        .o_out_valid(out_valid), .i_out_ready(out_ready),
        .o_out_result(out_result), .o_out_rd(out_rd), .o_out_write_en(out_we),
        .o_out_zero(out_zero), .o_out_neg(out_neg),
        .o_fwd_valid(fwd_valid), .o_fwd_rd(fwd_rd), .o_fwd_result(fwd_result)
    );

    // Advance past the next rising edge; inputs change 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Move to the falling edge to sample outputs for the current cycle.
    task automatic sample();
        @(negedge clk);
    endtask

    task automatic drive(input logic v, input logic [WIDTH-1:0] r, input logic [RD_W-1:0] d, input logic we);
        in_valid = v; in_result = r; in_rd = d; in_we = we;
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
        drive(1'b0, '0, '0, 1'b0);
        tick(); sample();
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL rst_in_ready_during got=%b exp=0", in_ready); end
        tick();
        rst = 1'b0;
        sample();
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready got=%b exp=1", in_ready); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%b exp=0", out_valid); end
        total++; if (out_result !== 16'h0000 || out_rd !== 3'd0 || out_we !== 1'b0) begin bad++; $display("FAIL rst_out_fields got=%h/%0d/%b exp=0000/0/0", out_result, out_rd, out_we); end
        total++; if (fwd_valid !== 1'b0 || fwd_rd !== 3'd0 || fwd_result !== 16'h0000) begin bad++; $display("FAIL rst_fwd got=%b/%0d/%h exp=0/0/0000", fwd_valid, fwd_rd, fwd_result); end
        total++; if (out_zero !== 1'b0 || out_neg !== 1'b0) begin bad++; $display("FAIL rst_flags got=%b%b exp=00", out_zero, out_neg); end
    endtask

    task automatic test_single();
        tick();
        out_ready = 1'b1;
        drive(1'b1, 16'hF800, 3'd3, 1'b1);
        tick();
        drive(1'b0, '0, '0, 1'b0);
        sample();
        total++; if (out_valid !== 1'b1 || out_result !== 16'hF800 || out_rd !== 3'd3) begin bad++; $display("FAIL single_out got=%b/%h/%0d exp=1/f800/3", out_valid, out_result, out_rd); end
        total++; if (out_neg !== FLAGS || out_zero !== 1'b0) begin bad++; $display("FAIL single_flags got=neg%b zero%b exp=neg%b zero0", out_neg, out_zero, FLAGS); end
        total++; if (fwd_valid !== 1'b1 || fwd_rd !== 3'd3) begin bad++; $display("FAIL single_fwd got=%b/%0d exp=1/3", fwd_valid, fwd_rd); end
        tick(); sample();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL single_drain got=%b exp=0", out_valid); end
    endtask

    task automatic test_backpressure();
        tick();
        out_ready = 1'b0;
        drive(1'b1, 16'h0001, 3'd1, 1'b1);
        tick();
        drive(1'b1, 16'h0000, 3'd2, 1'b1);
        tick();
        drive(1'b0, '0, '0, 1'b0);
        sample();
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_full_in_ready got=%b exp=0", in_ready); end
        total++; if (out_result !== 16'h0001 || fwd_result !== 16'h0000 || fwd_rd !== 3'd2) begin bad++; $display("FAIL bp_head_fwd got=%h/%h/%0d exp=0001/0000/2", out_result, fwd_result, fwd_rd); end
        tick(); sample();
        total++; if (out_result !== 16'h0001 || out_rd !== 3'd1 || in_ready !== 1'b0) begin bad++; $display("FAIL bp_stable got=%h/%0d/%b exp=0001/1/0", out_result, out_rd, in_ready); end
        #1 out_ready = 1'b1;
        tick(); sample();
        total++; if (in_ready !== 1'b1 || out_valid !== 1'b1 || out_result !== 16'h0000) begin bad++; $display("FAIL bp_second got=%b/%b/%h exp=1/1/0000", in_ready, out_valid, out_result); end
        total++; if (out_zero !== FLAGS || out_neg !== 1'b0) begin bad++; $display("FAIL bp_zero got=zero%b neg%b exp=zero%b neg0", out_zero, out_neg, FLAGS); end
        tick(); sample();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_drain got=%b exp=0", out_valid); end
    endtask

    task automatic test_streaming();
        tick();
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, WIDTH'(i), RD_W'(i), 1'b1);
            sample();
            total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL stream_in_ready_%0d got=%b exp=1", i, in_ready); end
            if (i > 0) begin
                total++; if (out_valid !== 1'b1 || out_result !== WIDTH'(i - 1)) begin bad++; $display("FAIL stream_out_%0d got=%b/%h exp=1/%h", i, out_valid, out_result, WIDTH'(i - 1)); end
            end
            tick();
        end
        drive(1'b0, '0, '0, 1'b0);
        sample();
        total++; if (out_valid !== 1'b1 || out_result !== 16'h0007 || out_rd !== 3'd7) begin bad++; $display("FAIL stream_last got=%b/%h/%0d exp=1/0007/7", out_valid, out_result, out_rd); end
        tick(); sample();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL stream_drain got=%b exp=0", out_valid); end
    endtask

    task automatic test_back_to_back();
        tick();
        out_ready = 1'b0;
        drive(1'b1, 16'h1234, 3'd4, 1'b1);
        tick();
        out_ready = 1'b1;
        drive(1'b1, 16'hABCD, 3'd5, 1'b1);
        sample();
        total++; if (out_result !== 16'h1234 || out_rd !== 3'd4 || in_ready !== 1'b1) begin bad++; $display("FAIL b2b_a got=%h/%0d/%b exp=1234/4/1", out_result, out_rd, in_ready); end
        tick();
        out_ready = 1'b0;
        drive(1'b0, '0, '0, 1'b0);
        sample();
        total++; if (out_valid !== 1'b1 || out_result !== 16'hABCD || fwd_result !== 16'hABCD || in_ready !== 1'b1) begin bad++; $display("FAIL b2b_b got=%b/%h/%h/%b exp=1/abcd/abcd/1", out_valid, out_result, fwd_result, in_ready); end
        #1 out_ready = 1'b1;
        tick(); sample();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL b2b_count1 got=%b exp=0", out_valid); end
    endtask

    task automatic test_fwd_no_write();
        tick();
        out_ready = 1'b0;
        drive(1'b1, 16'h5A5A, 3'd6, 1'b1);
        tick();
        drive(1'b1, 16'h0F0F, 3'd2, 1'b0);
        tick();
        drive(1'b0, '0, '0, 1'b0);
        sample();
        total++; if (fwd_valid !== 1'b0 || fwd_rd !== 3'd2 || out_we !== 1'b1) begin bad++; $display("FAIL fwd_nowrite got=%b/%0d/%b exp=0/2/1", fwd_valid, fwd_rd, out_we); end
        #1 out_ready = 1'b1;
        tick(); sample();
        total++; if (out_result !== 16'h0F0F || out_we !== 1'b0 || fwd_valid !== 1'b0) begin bad++; $display("FAIL fwd_nowrite_head got=%h/%b/%b exp=0f0f/0/0", out_result, out_we, fwd_valid); end
        tick();
    endtask

    task automatic test_flush();
        tick();
        out_ready = 1'b0;
        drive(1'b1, 16'h1111, 3'd1, 1'b1);
        tick();
        drive(1'b1, 16'h2222, 3'd2, 1'b1);
        tick();
        drive(1'b1, 16'h3333, 3'd3, 1'b1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        drive(1'b0, '0, '0, 1'b0);
        sample();
        total++; if (out_valid !== 1'b0 || fwd_valid !== 1'b0 || in_ready !== 1'b1) begin bad++; $display("FAIL flush_full got=%b/%b/%b exp=0/0/1", out_valid, fwd_valid, in_ready); end
        #1 drive(1'b1, 16'h4444, 3'd4, 1'b1);
        tick();
        drive(1'b1, 16'h5555, 3'd5, 1'b1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        drive(1'b0, '0, '0, 1'b0);
        out_ready = 1'b1;
        sample();
        total++; if (out_valid !== 1'b0 || fwd_valid !== 1'b0) begin bad++; $display("FAIL flush_push got=%b/%b exp=0/0", out_valid, fwd_valid); end
        tick(); sample();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_ghost got=%b/%h exp=0", out_valid, out_result); end
    endtask

    task automatic test_reset_mid();
        tick();
        out_ready = 1'b0;
        drive(1'b1, 16'h8001, 3'd7, 1'b1);
        tick();
        drive(1'b1, 16'hC0DE, 3'd6, 1'b1);
        tick();
        drive(1'b0, '0, '0, 1'b0);
        rst = 1'b1;
        sample();
        total++; if (in_ready !== 1'b0 || out_valid !== 1'b1) begin bad++; $display("FAIL rstmid_before got=%b/%b exp=0/1", in_ready, out_valid); end
        tick();
        rst = 1'b0;
        sample();
        total++; if (out_valid !== 1'b0 || fwd_valid !== 1'b0 || in_ready !== 1'b1) begin bad++; $display("FAIL rstmid_ctl got=%b/%b/%b exp=0/0/1", out_valid, fwd_valid, in_ready); end
        total++; if (out_result !== 16'h0000 || out_rd !== 3'd0 || out_we !== 1'b0 || out_zero !== 1'b0 || out_neg !== 1'b0) begin bad++; $display("FAIL rstmid_out got=%h/%0d/%b/%b/%b exp=0000/0/0/0/0", out_result, out_rd, out_we, out_zero, out_neg); end
        total++; if (fwd_rd !== 3'd0 || fwd_result !== 16'h0000) begin bad++; $display("FAIL rstmid_fwd got=%0d/%h exp=0/0000", fwd_rd, fwd_result); end
    endtask

    task automatic test_zero_flag();
        tick();
        out_ready = 1'b0;
        drive(1'b1, 16'h0000, 3'd1, 1'b1);
        tick();
        drive(1'b0, '0, '0, 1'b0);
        sample();
        total++; if (out_valid !== 1'b1 || out_zero !== FLAGS || out_neg !== 1'b0) begin bad++; $display("FAIL zero_flag got=%b/zero%b/neg%b exp=1/zero%b/neg0", out_valid, out_zero, out_neg, FLAGS); end
        #1 out_ready = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_single();
        test_backpressure();
        test_streaming();
        test_back_to_back();
        test_fwd_no_write();
        test_flush();
        test_reset_mid();
        test_zero_flag();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
